cmd_exec: RTL and testbench

- Consumer end of the 16-bit command interface driven by the tour command generator and the UART command path.
- Accepts one command at a time and handles it as follows:
  - calibrate: starts calibration.
  - move: turns to the commanded heading, then ramps forward speed up.
  - during the move, counts centre-IR line crossings and ramps down after the commanded number of squares.
- Reports completion with a send_resp pulse, which the generator uses to issue its next vertical/horizontal leg.

---
 rtl/cmd_exec.sv | 161 ++++++++++++++++
 tb/tb_cmd_exec.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_exec.sv
// Command executor: accepts one 16-bit command at a time, runs calibration or a
// turn-then-drive move, and pulses send_resp when the command has finished.
module cmd_exec #(
    parameter bit          FAST_SIM = 1'b1,
    parameter logic [9:0]  MAX_SPD  = 10'h2A0,
    parameter logic [11:0] HEAD_TOL = 12'h02C
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] cmd,
    input  logic        cmd_rdy,
    output logic        clr_cmd_rdy,
    output logic        send_resp,
    output logic        strt_cal,
    input  logic        cal_done,
    input  logic [11:0] heading,
    input  logic        heading_rdy,
    input  logic        cntrIR,
    output logic [11:0] dsrd_hdng,
    output logic [9:0]  frwrd,
    output logic        moving,
    output logic        fanfare_go
);

    localparam logic [9:0] INC = FAST_SIM ? 10'h020 : 10'h004;
    localparam logic [9:0] DEC = FAST_SIM ? 10'h040 : 10'h008;

    typedef enum logic [2:0] {IDLE, CAL, TURN, RAMPUP, RAMPDN} state_t;

    state_t      state_q, state_d;
    logic [3:0]  opc_q, opc_d;
    logic [3:0]  sq_q, sq_d;
    logic [4:0]  lines_q, lines_d;
    logic        ir_q;
    logic [11:0] hdng_q, hdng_d;
    logic [9:0]  frwrd_q, frwrd_d;
    logic        clr_q, clr_d, resp_q, resp_d, cal_q, cal_d;
    logic        fan_q, fan_d, mov_q, mov_d;

    logic [11:0] err, abs_err, acc_hdng;
    logic [10:0] up_sum;
    logic [9:0]  up_sat, dn_sat;
    logic        ir_rise;

    assign err      = heading - hdng_q;
    assign abs_err  = err[11] ? (~err + 12'd1) : err;
    assign acc_hdng = (cmd[11:4] == 8'h00) ? 12'h000 : {cmd[11:4], 4'hF};
    assign up_sum   = {1'b0, frwrd_q} + {1'b0, INC};
    assign up_sat   = (up_sum > {1'b0, MAX_SPD}) ? MAX_SPD : up_sum[9:0];
    assign dn_sat   = (frwrd_q > DEC) ? (frwrd_q - DEC) : 10'h000;
    assign ir_rise  = cntrIR & ~ir_q;

    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        sq_d    = sq_q;
        lines_d = lines_q;
        hdng_d  = hdng_q;
        frwrd_d = frwrd_q;
        mov_d   = mov_q;
        clr_d   = 1'b0;
        resp_d  = 1'b0;
        cal_d   = 1'b0;
        fan_d   = 1'b0;

        if ((state_q == RAMPUP || state_q == RAMPDN) && ir_rise && lines_q != 5'd31)
            lines_d = lines_q + 5'd1;

        case (state_q)
            IDLE: begin
                // clr_q blocks re-accepting a word whose source has not yet seen the clear
                if (cmd_rdy && !clr_q) begin
                    opc_d   = cmd[15:12];
                    sq_d    = cmd[3:0];
                    clr_d   = 1'b1;
                    lines_d = 5'd0;
                    case (cmd[15:12])
                        4'h0: begin
                            state_d = CAL;
                            cal_d   = 1'b1;
                            hdng_d  = acc_hdng;
                        end
                        4'h2, 4'h3: begin
                            state_d = TURN;
                            mov_d   = 1'b1;
                            frwrd_d = 10'h000;
                            hdng_d  = acc_hdng;
                        end
                        default: ;
                    endcase
                end
            end
            CAL: begin
                if (cal_done) begin
                    resp_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            TURN: begin
                if (heading_rdy && abs_err < HEAD_TOL)
                    state_d = RAMPUP;
            end
            RAMPUP: begin
                if (heading_rdy)
                    frwrd_d = up_sat;
                if (lines_q == {sq_q, 1'b0})
                    state_d = RAMPDN;
            end
            RAMPDN: begin
                if (frwrd_q == 10'h000) begin
                    resp_d  = 1'b1;
                    fan_d   = (opc_q == 4'h3);
                    mov_d   = 1'b0;
                    state_d = IDLE;
                end else if (heading_rdy) begin
                    frwrd_d = dn_sat;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            opc_q   <= 4'h0;
            sq_q    <= 4'h0;
            lines_q <= 5'd0;
            ir_q    <= 1'b0;
            hdng_q  <= 12'h000;
            frwrd_q <= 10'h000;
            clr_q   <= 1'b0;
            resp_q  <= 1'b0;
            cal_q   <= 1'b0;
            fan_q   <= 1'b0;
            mov_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            sq_q    <= sq_d;
            lines_q <= lines_d;
            ir_q    <= cntrIR;
            hdng_q  <= hdng_d;
            frwrd_q <= frwrd_d;
            clr_q   <= clr_d;
            resp_q  <= resp_d;
            cal_q   <= cal_d;
            fan_q   <= fan_d;
            mov_q   <= mov_d;
        end
    end

    assign clr_cmd_rdy = clr_q;
    assign send_resp   = resp_q;
    assign strt_cal    = cal_q;
    assign fanfare_go  = fan_q;
    assign moving      = mov_q;
    assign dsrd_hdng   = hdng_q;
    assign frwrd       = frwrd_q;

endmodule

// File: tb/tb_cmd_exec.sv
// Bench for cmd_exec: directed commands push expected clear/response events into
// an ordered queue; a negedge monitor pops and checks each event the DUT emits.
module tb_cmd_exec;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cmd = 16'h0000;
    logic        cmd_rdy = 1'b0;
    logic        cal_done = 1'b0;
    logic [11:0] heading = 12'h000;
    logic        heading_rdy = 1'b0;
    logic        cntrIR = 1'b0;
    logic        clr_cmd_rdy, send_resp, strt_cal, moving, fanfare_go;
    logic [11:0] dsrd_hdng;
    logic [9:0]  frwrd;

    always #5 clk = ~clk;

    cmd_exec #(.FAST_SIM(1'b1), .MAX_SPD(10'h2A0), .HEAD_TOL(12'h02C)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .send_resp(send_resp), .strt_cal(strt_cal),
        .cal_done(cal_done), .heading(heading), .heading_rdy(heading_rdy),
        .cntrIR(cntrIR), .dsrd_hdng(dsrd_hdng), .frwrd(frwrd),
        .moving(moving), .fanfare_go(fanfare_go)
    );

    typedef struct {bit is_resp; bit strt; bit mov; bit fan;} ev_t;
    ev_t evq[$];

    int checks = 0, errors = 0, clr_cnt = 0, resp_cnt = 0;
    int rbase, cbase;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: event seen/missed at %0t", nm, $time);
    endtask

    // Monitor: every clear/response pulse must match the next queued expectation
    always @(negedge clk) begin
        ev_t e;
        if (clr_cmd_rdy) begin
            clr_cnt++;
            if (evq.size() == 0 || evq[0].is_resp) fail("unexpected_clr");
            else begin
                e = evq.pop_front();
                chk("clr_strt_cal", strt_cal, e.strt);
                chk("clr_moving", moving, e.mov);
                chk("clr_frwrd", frwrd, 0);
            end
        end
        if (send_resp) begin
            resp_cnt++;
            if (evq.size() == 0 || !evq[0].is_resp) fail("unexpected_resp");
            else begin
                e = evq.pop_front();
                chk("resp_fanfare", fanfare_go, e.fan);
                chk("resp_moving", moving, 0);
                chk("resp_frwrd", frwrd, 0);
            end
        end
        if (strt_cal && !clr_cmd_rdy) fail("strt_cal_without_clr");
        if (fanfare_go && !send_resp) fail("fanfare_without_resp");
    end

    task automatic wait_clr(input int base);
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            if (clr_cnt != base) return;
        end
        fail("clr_timeout");
    endtask

    task automatic wait_resp(input int base);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (resp_cnt != base) return;
        end
        fail("resp_timeout");
    endtask

    task automatic issue(input logic [15:0] c, input bit strt, input bit mov,
                         input bit has_resp, input bit fan, input bit hold);
        int base;
        base = clr_cnt;
        evq.push_back('{1'b0, strt, mov, 1'b0});
        if (has_resp) evq.push_back('{1'b1, 1'b0, 1'b0, fan});
        @(posedge clk); #1;
        cmd = c;
        cmd_rdy = 1'b1;
        wait_clr(base);
        if (!hold) cmd_rdy = 1'b0;
    endtask

    task automatic hr();
        @(posedge clk); #1 heading_rdy = 1'b1;
        @(posedge clk); #1 heading_rdy = 1'b0;
    endtask

    task automatic ir_edges(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 cntrIR = 1'b1;
            repeat (2) @(posedge clk);
            #1 cntrIR = 1'b0;
            repeat (2) @(posedge clk);
        end
    endtask

    task automatic cal_pulse();
        @(posedge clk); #1 cal_done = 1'b1;
        @(posedge clk); #1 cal_done = 1'b0;
    endtask

    initial begin
        #12;
        chk("rst_clr", clr_cmd_rdy, 0);
        chk("rst_resp", send_resp, 0);
        chk("rst_strt_cal", strt_cal, 0);
        chk("rst_dsrd", dsrd_hdng, 0);
        chk("rst_frwrd", frwrd, 0);
        chk("rst_moving", moving, 0);
        chk("rst_fanfare", fanfare_go, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // calibrate
        issue(16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 chk("cal_moving", moving, 0);
        rbase = resp_cnt;
        cal_pulse();
        wait_resp(rbase);
        repeat (5) @(posedge clk);

        // move 2 squares, heading 0, ramp to saturation then down
        issue(16'h2002, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("m1_dsrd", dsrd_hdng, 12'h000);
        hr();
        chk("m1_turn_exit_frwrd", frwrd, 10'h000);
        hr();
        chk("m1_first_inc", frwrd, 10'h020);
        repeat (24) hr();
        chk("m1_saturate", frwrd, 10'h2A0);
        ir_edges(4);
        repeat (3) @(posedge clk);
        hr();
        chk("m1_first_dec", frwrd, 10'h260);
        chk("m1_moving", moving, 1);
        rbase = resp_cnt;
        repeat (10) hr();
        chk("m1_clamp_zero", frwrd, 10'h000);
        wait_resp(rbase);
        chk("m1_moving_drop", moving, 0);

        // heading off: stays in TURN; edges during TURN ignored
        heading = 12'h000;
        issue(16'h2BF1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) hr();
        ir_edges(1);
        chk("m2_turn_frwrd", frwrd, 10'h000);
        chk("m2_dsrd", dsrd_hdng, 12'hBFF);
        heading = 12'hBF8;
        hr();
        repeat (3) hr();
        chk("m2_ramp", frwrd, 10'h060);
        ir_edges(1);
        repeat (3) @(posedge clk);
        hr();
        chk("m2_one_edge_still_up", frwrd, 10'h080);
        ir_edges(1);
        repeat (3) @(posedge clk);
        rbase = resp_cnt;
        hr();
        chk("m2_dec", frwrd, 10'h040);
        hr();
        wait_resp(rbase);

        // fanfare move, tolerance boundary (err 44 stays, 43 passes)
        heading = 12'h82B;
        issue(16'h37F2, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("m3_dsrd", dsrd_hdng, 12'h7FF);
        hr();
        heading = 12'h82A;
        hr();
        chk("m3_tol_boundary", frwrd, 10'h000);
        hr();
        chk("m3_inc", frwrd, 10'h020);
        hr();
        ir_edges(4);
        repeat (3) @(posedge clk);
        rbase = resp_cnt;
        hr();
        wait_resp(rbase);

        // unsupported opcode: consumed, nothing else
        issue(16'h5123, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (100) @(posedge clk);
        #1;
        chk("bad_dsrd_kept", dsrd_hdng, 12'h7FF);
        chk("bad_frwrd", frwrd, 10'h000);
        chk("bad_moving", moving, 0);

        // move without fanfare, next command held during the move
        heading = 12'h7FF;
        issue(16'h27F2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cmd = 16'h0000;
        evq.push_back('{1'b0, 1'b1, 1'b0, 1'b0});
        evq.push_back('{1'b1, 1'b0, 1'b0, 1'b0});
        hr();
        hr();
        chk("m4_inc", frwrd, 10'h020);
        cal_pulse();
        ir_edges(4);
        repeat (3) @(posedge clk);
        rbase = resp_cnt;
        cbase = clr_cnt;
        hr();
        wait_resp(rbase);
        wait_clr(cbase);
        cmd_rdy = 1'b0;
        chk("m4_cal_moving", moving, 0);
        rbase = resp_cnt;
        cal_pulse();
        wait_resp(rbase);

        // asynchronous reset mid-move with a held command
        heading = 12'h3FF;
        issue(16'h23F4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        cmd = 16'h0000;
        hr();
        repeat (8) hr();
        chk("m5_frwrd", frwrd, 10'h100);
        chk("m5_dsrd", dsrd_hdng, 12'h3FF);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        chk("arst_frwrd", frwrd, 10'h000);
        chk("arst_moving", moving, 0);
        chk("arst_dsrd", dsrd_hdng, 12'h000);
        chk("arst_pending", evq.size(), 1);
        evq.delete();
        evq.push_back('{1'b0, 1'b1, 1'b0, 1'b0});
        evq.push_back('{1'b1, 1'b0, 1'b0, 1'b0});
        cbase = clr_cnt;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_clr(cbase);
        cmd_rdy = 1'b0;
        rbase = resp_cnt;
        cal_pulse();
        wait_resp(rbase);

        repeat (10) @(posedge clk);
        #1 chk("queue_drained", evq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
